// File: rtl/xs3_display_mux.sv
// xs3_display_mux: decodes strobed Excess-3 key codes into a 4-digit entry
// buffer and drives a time-multiplexed common-anode 7-segment display.
module xs3_display_mux #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] xs3_in,
    input  logic       xs3_valid,
    input  logic       clr,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       err,
    output logic [2:0] digit_count
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit
    function automatic logic [6:0] seg_map(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    digits [4];
    logic          code_ok;
    logic [3:0]    new_digit;

    // XS3 validity check and decode of the incoming code
    always_comb begin
        code_ok   = (xs3_in >= 4'd3) && (xs3_in <= 4'd12);
        new_digit = xs3_in - 4'd3;
    end

    // Scan prescaler and digit index; index advances on prescaler wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Entry buffer: clear wins over a strobe, valid codes shift in, invalid set err
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int unsigned i = 0; i < 4; i++) digits[i] <= '0;
            digit_count <= '0;
            err         <= 1'b0;
        end else if (xs3_valid) begin
            if (code_ok) begin
                digits[3] <= digits[2];
                digits[2] <= digits[1];
                digits[1] <= digits[0];
                digits[0] <= new_digit;
                if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end
    end

    // Registered display drive from the current index and buffer contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= BLANK;
        end else begin
            an <= ~(4'b0001 << idx);
            if ({1'b0, idx} >= digit_count) seg <= BLANK;
            else                            seg <= seg_map(digits[idx]);
        end
    end

endmodule

// File: tb/tb_xs3_display_mux.sv
// Testbench for xs3_display_mux: directed steps followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_xs3_display_mux;

    localparam int unsigned SD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] xs3_in;
    logic       xs3_valid;
    logic       clr;
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
    logic [2:0] digit_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         dq[$];
    logic       m_err;
    int         k;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] seg_tab [10];

    xs3_display_mux #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .xs3_in(xs3_in), .xs3_valid(xs3_valid),
        .clr(clr), .an(an), .seg(seg), .err(err), .digit_count(digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare all outputs
    task automatic step(input logic r, input logic v, input logic [3:0] c, input logic cl);
        int i;
        rst_n = r; xs3_valid = v; xs3_in = c; clr = cl;
        @(posedge clk);
        if (!r) begin
            exp_an = 4'b1111; exp_seg = 7'b1111111;
            dq.delete(); m_err = 1'b0; k = 0;
        end else begin
            k++;
            i = ((k - 1) / SD) % 4;
            exp_an = ~(4'b0001 << i);
            exp_seg = (i < dq.size()) ? seg_tab[dq[dq.size() - 1 - i]] : 7'b1111111;
            if (cl) begin
                dq.delete(); m_err = 1'b0;
            end else if (v) begin
                if (c >= 3 && c <= 12) begin
                    dq.push_back(int'(c) - 3);
                    if (dq.size() > 4) void'(dq.pop_front());
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        #1;
        check("an", {4'b0, an}, {4'b0, exp_an});
        check("seg", {1'b0, seg}, {1'b0, exp_seg});
        check("err", {7'b0, err}, {7'b0, m_err});
        check("digit_count", {5'b0, digit_count}, 8'(dq.size()));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b1, 1'b1, c, 1'b0);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        m_err = 1'b0; k = 0;
        rst_n = 1'b0; xs3_valid = 1'b0; xs3_in = '0; clr = 1'b0;

        // reset and first edge after release
        step(1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h5, 1'b0);
        check("rst_an", {4'b0, an}, 8'h0F);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        idle(1);
        check("first_an", {4'b0, an}, 8'h0E);

        // single digit 1, full refresh
        key(4'b0100);
        check("single_count", {5'b0, digit_count}, 8'd1);
        idle(18);

        // overflow: digits 3..7 back to back, newest 7 in d0
        key(4'b0110); key(4'b0111); key(4'b1000); key(4'b1001); key(4'b1010);
        check("ovf_count", {5'b0, digit_count}, 8'd4);
        idle(17);

        // invalid code after 9, then a valid 0
        step(1'b1, 1'b0, 4'h0, 1'b1);
        key(4'b1100);
        key(4'b1101);
        check("inv_err", {7'b0, err}, 8'd1);
        key(4'b0011);
        check("recover_err", {7'b0, err}, 8'd0);
        idle(17);

        // clear wins over simultaneous strobe
        step(1'b1, 1'b1, 4'b0101, 1'b1);
        check("clr_count", {5'b0, digit_count}, 8'd0);
        idle(17);

        // invalid codes at both ends with a digit present
        key(4'b0111);
        key(4'b0000);
        key(4'b1111);
        idle(17);

        // every valid code shown at d0
        for (int c = 3; c <= 12; c++) begin
            key(4'(c));
            idle(16);
        end

        // reset mid-scan with three digits stored and a pending strobe
        step(1'b1, 1'b0, 4'h0, 1'b1);
        key(4'h4); key(4'h8); key(4'hB);
        idle(6);
        step(1'b0, 1'b1, 4'h6, 1'b0);
        check("mid_rst_an", {4'b0, an}, 8'h0F);
        check("mid_rst_count", {5'b0, digit_count}, 8'd0);
        idle(1);
        check("mid_rel_an", {4'b0, an}, 8'h0E);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
